// File: rtl/serial_command_controller.sv
// serial_command_controller
// Decodes a byte-oriented command stream from an asynchronous serial slave:
//   'W' addr data -> one-cycle write strobe to the phase register file
//   'R' addr      -> register contents presented on tx_data until the next byte
//   'F'           -> one-cycle emission burst trigger
//   'C'           -> clear sticky error flags
// All outputs are registered; err is sticky until 'C' or reset.

module serial_command_controller #(
   parameter int NCH     = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic       CLK,
   input  logic       res,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [7:0] tx_data,
   output logic       wr_en,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [7:0] rd_data,
   output logic       fire,
   output logic       busy,
   output logic [1:0] err
);

   localparam logic [7:0] BYTE_W = 8'h57;
   localparam logic [7:0] BYTE_R = 8'h52;
   localparam logic [7:0] BYTE_F = 8'h46;
   localparam logic [7:0] BYTE_C = 8'h43;

   // One bit wider than a byte so NCH = 16 (or any legal value) compares cleanly
   localparam logic [8:0]  NCH_LIM = 9'(NCH);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_EXEC = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_WR   = 2'd1,
      CMD_RD   = 2'd2,
      CMD_FIRE = 2'd3
   } cmd_t;

   // Synchronizer and edge-detect state
   logic        sync1_r, sync2_r, sync3_r;
   logic        sampled_r;   // first real post-reset sample has been taken
   logic        armed_r;     // synchronized rx_valid has been seen low since reset
   logic        strobe_r;

   // FSM and datapath state
   state_t      state_r, state_s;
   cmd_t        cmd_r, cmd_s;
   logic [15:0] cnt_r, cnt_s;
   logic [1:0]  err_r, err_s;
   logic [3:0]  wr_addr_r, wr_addr_s;
   logic [7:0]  wr_data_r, wr_data_s;
   logic        wr_en_r, wr_en_s;
   logic        fire_r, fire_s;
   logic        busy_r;
   logic [7:0]  tx_data_r, tx_data_s;
   logic        tx_hold_r, tx_hold_s;  // tx_data is showing read data, not status
   logic        addr_bad_s;

   assign tx_data = tx_data_r;
   assign wr_en   = wr_en_r;
   assign wr_addr = wr_addr_r;
   assign wr_data = wr_data_r;
   assign fire    = fire_r;
   assign busy    = busy_r;
   assign err     = err_r;

   assign addr_bad_s = ({1'b0, rx_data} >= NCH_LIM);

   // Two-flop synchronizer plus rising-edge detector producing a registered byte strobe.
   // The arm flag blocks a strobe when rx_valid is already high as reset is released.
   always_ff @(posedge CLK) begin
      if (res) begin
         sync1_r   <= 1'b0;
         sync2_r   <= 1'b0;
         sync3_r   <= 1'b0;
         sampled_r <= 1'b0;
         armed_r   <= 1'b0;
         strobe_r  <= 1'b0;
      end else begin
         sync1_r   <= rx_valid;
         sync2_r   <= sync1_r;
         sync3_r   <= sync2_r;
         sampled_r <= 1'b1;
         armed_r   <= armed_r | (sampled_r & ~sync1_r);
         strobe_r  <= armed_r & sync2_r & ~sync3_r;
      end
   end

   // Next-state, timeout, error and output-strobe decode; the byte is consumed in the strobe cycle
   always_comb begin
      state_s   = state_r;
      cmd_s     = cmd_r;
      cnt_s     = cnt_r;
      err_s     = err_r;
      wr_addr_s = wr_addr_r;
      wr_data_s = wr_data_r;
      wr_en_s   = 1'b0;
      fire_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (strobe_r) begin
               case (rx_data)
                  BYTE_W: begin
                     cmd_s   = CMD_WR;
                     state_s = ST_ADDR;
                  end
                  BYTE_R: begin
                     cmd_s   = CMD_RD;
                     state_s = ST_ADDR;
                  end
                  BYTE_F: begin
                     cmd_s   = CMD_FIRE;
                     state_s = ST_EXEC;
                     fire_s  = 1'b1;
                  end
                  BYTE_C: begin
                     err_s = 2'b00;
                  end
                  default: begin
                     err_s[0] = 1'b1;
                  end
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_ADDR: begin
            if (strobe_r) begin
               cnt_s     = 16'd0;
               wr_addr_s = rx_data[3:0];
               if (addr_bad_s) begin
                  err_s[0] = 1'b1;
                  state_s  = ST_IDLE;
               end else if (cmd_r == CMD_WR) begin
                  state_s = ST_DATA;
               end else begin
                  state_s = ST_EXEC;
               end
            end else if (cnt_r == TO_LAST) begin
               err_s[1] = 1'b1;
               state_s  = ST_IDLE;
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end

         ST_DATA: begin
            if (strobe_r) begin
               cnt_s     = 16'd0;
               wr_data_s = rx_data;
               wr_en_s   = 1'b1;
               state_s   = ST_EXEC;
            end else if (cnt_r == TO_LAST) begin
               err_s[1] = 1'b1;
               state_s  = ST_IDLE;
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end

         ST_EXEC: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Counter always restarts from zero whenever the FSM sits in or returns to IDLE
      if (state_s == ST_IDLE) begin
         cnt_s = 16'd0;
      end else begin
         cnt_s = cnt_s;
      end
   end

   // tx_data source select: read data latched after an R, otherwise the live status byte
   always_comb begin
      tx_data_s = tx_data_r;
      tx_hold_s = tx_hold_r;
      if ((state_r == ST_EXEC) && (cmd_r == CMD_RD)) begin
         tx_data_s = rd_data;
         tx_hold_s = 1'b1;
      end else if (strobe_r) begin
         tx_data_s = {6'b000000, err_s};
         tx_hold_s = 1'b0;
      end else if (tx_hold_r) begin
         tx_data_s = tx_data_r;
         tx_hold_s = 1'b1;
      end else begin
         tx_data_s = {6'b000000, err_s};
         tx_hold_s = 1'b0;
      end
   end

   // State and registered-output update
   always_ff @(posedge CLK) begin
      if (res) begin
         state_r   <= ST_IDLE;
         cmd_r     <= CMD_NONE;
         cnt_r     <= 16'd0;
         err_r     <= 2'b00;
         wr_addr_r <= 4'd0;
         wr_data_r <= 8'd0;
         wr_en_r   <= 1'b0;
         fire_r    <= 1'b0;
         busy_r    <= 1'b0;
         tx_data_r <= 8'h00;
         tx_hold_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         cmd_r     <= cmd_s;
         cnt_r     <= cnt_s;
         err_r     <= err_s;
         wr_addr_r <= wr_addr_s;
         wr_data_r <= wr_data_s;
         wr_en_r   <= wr_en_s;
         fire_r    <= fire_s;
         busy_r    <= (state_s != ST_IDLE);
         tx_data_r <= tx_data_s;
         tx_hold_r <= tx_hold_s;
      end
   end

endmodule

// File: tb/tb_serial_command_controller.sv
// Testbench for serial_command_controller: expected write and fire events are
// queued as commands are sent and retired by a monitor when the DUT pulses.

module tb_serial_command_controller;

   localparam int NCH     = 16;
   localparam int TIMEOUT = 40;

   logic       CLK;
   logic       res;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       fire;
   logic       busy;
   logic [1:0] err;

   int n_cmp = 0;
   int n_mis = 0;

   logic [11:0] exp_wr[$];
   int          exp_fire[$];
   logic [12:0] exp_w_v;
   int          exp_f_v;

   serial_command_controller #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
      .CLK      (CLK),
      .res      (res),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .tx_data  (tx_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .fire     (fire),
      .busy     (busy),
      .err      (err)
   );

   // Register file model: address 5 holds 0xA2, others a recognisable pattern
   assign rd_data = (wr_addr == 4'd5) ? 8'hA2 : {4'hC, wr_addr};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      rx_data  = b;
      rx_valid = 1'b1;
      repeat (6) @(negedge CLK);
      rx_valid = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   task automatic pulse_res();
      @(negedge CLK);
      res = 1'b1;
      repeat (2) @(negedge CLK);
      res = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tx"},   tx_data, 8'h00);
      chk({tag, "_err"},  err,     2'b00);
      chk({tag, "_busy"}, busy,    1'b0);
      chk({tag, "_wen"},  wr_en,   1'b0);
      chk({tag, "_fire"}, fire,    1'b0);
      chk({tag, "_addr"}, wr_addr, 4'd0);
      chk({tag, "_data"}, wr_data, 8'd0);
   endtask

   // Monitor: every write or fire pulse must match a queued expectation
   always @(negedge CLK) begin
      if (wr_en) begin
         if (exp_wr.size() > 0) exp_w_v = {1'b1, exp_wr.pop_front()};
         else                   exp_w_v = 13'h0000;
         chk("wr_pulse", {19'd0, 1'b1, wr_addr, wr_data}, {19'd0, exp_w_v});
      end
      if (fire) begin
         if (exp_fire.size() > 0) exp_f_v = exp_fire.pop_front();
         else                     exp_f_v = 0;
         chk("fire_pulse", 32'd1, exp_f_v);
      end
   end

   // Watchdog so the bench cannot hang
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      res      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge CLK);
      chk_reset_vals("rst");
      res = 1'b0;
      repeat (4) @(negedge CLK);

      // Write frame
      exp_wr.push_back({4'd3, 8'h7F});
      send_byte(8'h57);
      send_byte(8'h03);
      send_byte(8'h7F);
      chk("wr_err",  err,     2'b00);
      chk("wr_busy", busy,    1'b0);
      chk("wr_addr", wr_addr, 4'd3);
      chk("wr_data", wr_data, 8'h7F);

      // Read frame: tx shows read data until the next strobe
      send_byte(8'h52);
      send_byte(8'h05);
      chk("rd_tx", tx_data, 8'hA2);
      repeat (10) @(negedge CLK);
      chk("rd_tx_hold", tx_data, 8'hA2);
      send_byte(8'h43);
      chk("rd_tx_revert", tx_data, 8'h00);

      // Fire latency: pulse visible only after the 4th edge following the rise
      @(negedge CLK);
      rx_data  = 8'h46;
      rx_valid = 1'b1;
      exp_fire.push_back(1);
      for (int i = 1; i <= 6; i++) begin
         @(posedge CLK);
         #1;
         chk($sformatf("fire_lat%0d", i), fire, (i == 4));
      end
      @(negedge CLK);
      rx_valid = 1'b0;
      repeat (6) @(negedge CLK);

      // Bad command, then clear
      send_byte(8'h99);
      chk("bad_err", err,     2'b01);
      chk("bad_tx",  tx_data, 8'h01);
      send_byte(8'h43);
      chk("clr_err", err,     2'b00);
      chk("clr_tx",  tx_data, 8'h00);

      // Timeout after W with no further byte
      send_byte(8'h57);
      chk("to_busy_pre", busy, 1'b1);
      chk("to_err_pre",  err,  2'b00);
      repeat (TIMEOUT) @(negedge CLK);
      chk("to_err",  err,     2'b10);
      chk("to_busy", busy,    1'b0);
      chk("to_tx",   tx_data, 8'h02);
      exp_fire.push_back(1);
      send_byte(8'h46);
      chk("to_err_sticky", err, 2'b10);
      send_byte(8'h43);
      chk("to_clr", err, 2'b00);

      // Out-of-range address: no write
      send_byte(8'h57);
      send_byte(8'h10);
      chk("addr_err",  err,  2'b01);
      chk("addr_busy", busy, 1'b0);

      // Reset mid-frame after W, 0x02: abort, outputs back to reset values
      send_byte(8'h57);
      send_byte(8'h02);
      pulse_res();
      @(negedge CLK);
      chk_reset_vals("mid");

      // Reset on the edge that would enter EXEC, with rx_valid still high afterwards
      send_byte(8'h99);
      chk("pre_err", err, 2'b01);
      send_byte(8'h57);
      send_byte(8'h04);
      @(negedge CLK);
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      repeat (3) @(negedge CLK);
      res = 1'b1;
      repeat (2) @(negedge CLK);
      res = 1'b0;
      repeat (10) @(negedge CLK);
      chk_reset_vals("exec");
      rx_valid = 1'b0;
      repeat (6) @(negedge CLK);
      chk("exec_idle", busy, 1'b0);

      chk("wr_left",   exp_wr.size(),   0);
      chk("fire_left", exp_fire.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
